// File: rtl/nios2_mem_copy_master.sv
// Avalon-MM word-copy initiator for a fixed-latency (1-cycle) on-chip RAM port.
// Optional running checksum of copied words: define MEM_COPY_CHECKSUM_EN.
module nios2_mem_copy_master #(
    parameter int unsigned DEPTH  = 16000,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned LEN_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              mem_clken
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [31:0]       data_q;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    assign mem_clken     = 1'b1;
    assign mem_writedata = data_q;

    // Bus strobes are set on the edge entering RD/WR so every output is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            cnt_q          <= '0;
            data_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= 4'h0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        cnt_q <= len;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state          <= RD;
                            busy           <= 1'b1;
                            mem_chipselect <= 1'b1;
                            mem_write      <= 1'b0;
                            mem_byteenable <= 4'hF;
                            mem_address    <= src_addr;
                        end
                    end
                end
                RD: begin
                    state          <= CAP;
                    mem_chipselect <= 1'b0;
                    mem_byteenable <= 4'h0;
                end
                CAP: begin
                    data_q         <= mem_readdata;
                    state          <= WR;
                    mem_chipselect <= 1'b1;
                    mem_write      <= 1'b1;
                    mem_byteenable <= 4'hF;
                    mem_address    <= dst_q;
                end
                WR: begin
                    src_q          <= wrap_inc(src_q);
                    dst_q          <= wrap_inc(dst_q);
                    cnt_q          <= cnt_q - LEN_W'(1);
                    mem_write      <= 1'b0;
                    if (cnt_q == LEN_W'(1)) begin
                        state          <= DONE;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        mem_chipselect <= 1'b0;
                        mem_byteenable <= 4'h0;
                    end else begin
                        state          <= RD;
                        mem_chipselect <= 1'b1;
                        mem_byteenable <= 4'hF;
                        mem_address    <= wrap_inc(src_q);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] sum_q;

    // Cleared on an accepted start, accumulates each captured word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state == IDLE && start) begin
            sum_q <= '0;
        end else if (state == CAP) begin
            sum_q <= sum_q + mem_readdata;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_nios2_mem_copy_master.sv
// Directed bench for nios2_mem_copy_master with a RAM model and access scoreboard.
module tb_nios2_mem_copy_master;

    localparam int unsigned DEPTH  = 16000;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned LEN_W  = 15;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [31:0]       checksum;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              mem_clken;

    logic [31:0] ram    [0:DEPTH-1];
    logic [31:0] shadow [0:DEPTH-1];
    logic [ADDR_W-1:0] rd_q[$];
    wr_t               wr_q[$];
    logic [31:0]       exp_sum;

    int n_checks = 0;
    int n_fail   = 0;

    nios2_mem_copy_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .checksum(checksum),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_clken(mem_clken)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read latency 1.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) ram[mem_address] <= mem_writedata;
            else           mem_readdata     <= ram[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        ram[a]    = v;
        shadow[a] = v;
    endtask

    // Sequential reference copy: queues the expected bus accesses.
    task automatic push_copy(input int s, input int d, input int l);
        logic [31:0] v;
        exp_sum = '0;
        for (int k = 0; k < l; k++) begin
            v = shadow[(s + k) % DEPTH];
            rd_q.push_back(ADDR_W'((s + k) % DEPTH));
            wr_q.push_back('{ADDR_W'((d + k) % DEPTH), v});
            exp_sum = exp_sum + v;
            shadow[(d + k) % DEPTH] = v;
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset && mem_chipselect) begin
            check("byteenable", 32'(mem_byteenable), 32'hF);
            if (mem_write) begin
                if (wr_q.size() == 0) check("unexpected_write", 32'(mem_address), 32'hFFFF_FFFF);
                else begin
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(mem_address), 32'(e.a));
                    check("wr_data", mem_writedata, e.d);
                end
            end else begin
                if (rd_q.size() == 0) check("unexpected_read", 32'(mem_address), 32'hFFFF_FFFF);
                else check("rd_addr", 32'(mem_address), 32'(rd_q.pop_front()));
            end
        end
    end

    task automatic run_copy(input int s, input int d, input int l, input bit extra);
        int dc = -1;
        int dn = 0;
        int bb = 0;
        int cs = 0;
        push_copy(s, d, l);
        @(negedge clk);
        start = 1'b1; src_addr = ADDR_W'(s); dst_addr = ADDR_W'(d); len = LEN_W'(l);
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 3 * l + 6; n++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (dc < 0) dc = n;
            end
            if (busy !== (n <= 3 * l)) bb++;
            if (mem_chipselect) cs++;
            if (extra && n == 5) begin
                start = 1'b1; src_addr = '0; dst_addr = 14'd900; len = 15'd2;
            end
            if (extra && n == 6) start = 1'b0;
        end
        check("done_cycle", 32'(dc), 32'(3 * l + 1));
        check("done_count", 32'(dn), 32'd1);
        check("busy_pattern", 32'(bb), 32'd0);
        check("access_count", 32'(cs), 32'(2 * l));
`ifdef MEM_COPY_CHECKSUM_EN
        check("checksum", checksum, exp_sum);
`else
        check("checksum", checksum, 32'd0);
`endif
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) preload(i, 32'd0);
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_be", 32'(mem_byteenable), 32'd0);
        check("rst_clken", 32'(mem_clken), 32'd1);
        check("rst_checksum", checksum, 32'd0);
        reset = 1'b0;

        // Basic four-word copy.
        for (int i = 0; i < 4; i++) preload(10 + i, 32'(i + 1));
        run_copy(10, 100, 4, 1'b0);
        for (int i = 0; i < 4; i++) check("copy_ram", ram[100 + i], 32'(i + 1));

        // Zero length: done only, no bus traffic.
        preload(400, 32'h55);
        run_copy(7, 400, 0, 1'b0);
        check("len0_ram", ram[400], 32'h55);

        // Source wraps past the top of the RAM.
        preload(15998, 32'hA); preload(15999, 32'hB); preload(0, 32'hC);
        run_copy(15998, 200, 3, 1'b0);
        check("wrap_ram0", ram[200], 32'hA);
        check("wrap_ram1", ram[201], 32'hB);
        check("wrap_ram2", ram[202], 32'hC);

        // Overlapping regions with dst < src.
        for (int i = 0; i < 4; i++) preload(50 + i, 32'(i + 5));
        run_copy(51, 50, 3, 1'b0);
        for (int i = 0; i < 3; i++) check("overlap_ram", ram[50 + i], 32'(i + 6));

        // A start pulse while busy is ignored.
        run_copy(10, 500, 4, 1'b1);
        check("ignored_start_ram", ram[900], 32'd0);

        // Reset during CAP of word 1 aborts the copy.
        preload(301, 32'hDEAD);
        push_copy(10, 300, 1);
        rd_q.push_back(ADDR_W'(11));
        @(negedge clk);
        start = 1'b1; src_addr = 14'd10; dst_addr = 14'd300; len = 15'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cs", 32'(mem_chipselect), 32'd0);
        check("abort_write", 32'(mem_write), 32'd0);
        check("abort_addr", 32'(mem_address), 32'd0);
        check("abort_wdata", mem_writedata, 32'd0);
        check("abort_checksum", checksum, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_ram0", ram[300], 32'd1);
        check("abort_ram1", ram[301], 32'hDEAD);
        check("abort_ram2", ram[302], 32'd0);
        check("abort_rd_q", 32'(rd_q.size()), 32'd0);
        check("abort_wr_q", 32'(wr_q.size()), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
